delta_stage: RTL and testbench

Pipelined backpropagation delta generator for one layer of the training datapath. It joins two accumulator streams: neuron activation/target and backpropagated error/output. Per channel it computes a hidden-layer gated delta or an output-layer difference, applies a runtime arithmetic right shift as a learning-rate scale, and saturates to WV bits. The result is broadcast to NB consumers, typically the weight updater and the previous layer's error accumulator. This block replaces the single-cycle combinational delta path with a registered two-stage pipeline, adds parametrised fan-out, overflow-safe subtraction, scaling and saturation accounting.

---
 rtl/delta_pkg.sv | 42 ++++
 rtl/delta_lane.sv | 75 +++++++
 rtl/delta_stage.sv | 137 +++++++++++++
 tb/tb_delta_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_pkg.sv
// delta_stage shared widths, mode constants and value bounds.
// Build option: DELTA_SATCNT_EN enables the saturation event counter.
package delta_pkg;

    localparam int MODE_OUTPUT = 0;
    localparam int MODE_HIDDEN = 1;

    function automatic int f_wa1(input int np, input int wv);
        return $clog2(np) + 1 + wv;
    endfunction

    function automatic int f_wa(input int mode, input int np, input int nn,
                                input int wv);
        return (mode == MODE_HIDDEN) ? $clog2(nn) + wv : f_wa1(np, wv);
    endfunction

    function automatic int f_wd(input int mode, input int np, input int nn,
                                input int wv);
        int a;
        int b;
        a = f_wa1(np, wv);
        b = f_wa(mode, np, nn, wv);
        return ((a > b) ? a : b) + 1;
    endfunction

    function automatic int f_wsh(input int wv);
        return (wv > 1) ? $clog2(wv) : 1;
    endfunction

    function automatic int f_one(input int wv);
        return (1 << (wv - 1)) - 1;
    endfunction

    function automatic int f_max(input int wv);
        return (1 << (wv - 1)) - 1;
    endfunction

    function automatic int f_min(input int wv);
        return -(1 << (wv - 1));
    endfunction

endpackage

// File: rtl/delta_lane.sv
// delta_stage per-channel lane: stage-1 gate/subtract, stage-2 shift/clamp.
// Build option: none (saturation flag is always produced).
module delta_lane
    import delta_pkg::*;
#(
    parameter int MODE = MODE_HIDDEN,
    parameter int WA1  = 8,
    parameter int WA   = 7,
    parameter int WD   = 9,
    parameter int WV   = 4,
    parameter int WSH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  take,
    input  logic                  load,
    input  logic signed [WA1-1:0] a1,
    input  logic signed [WA-1:0]  a2,
    input  logic [WSH-1:0]        shift,
    output logic signed [WV-1:0]  q,
    output logic                  sat
);

    localparam logic signed [WD-1:0] ONE = WD'(f_one(WV));
    localparam logic signed [WD-1:0] HI  = WD'(f_max(WV));
    localparam logic signed [WD-1:0] LO  = WD'(f_min(WV));

    logic signed [WD-1:0] x1;
    logic signed [WD-1:0] x2;
    logic signed [WD-1:0] d;
    logic signed [WD-1:0] d_q;
    logic signed [WD-1:0] s;
    logic signed [WV-1:0] qn;
    logic                 hi;
    logic                 lo;

    // WD is one bit wider than either operand, so the subtract never wraps
    assign x1 = {{(WD-WA1){a1[WA1-1]}}, a1};
    assign x2 = {{(WD-WA){a2[WA-1]}}, a2};

    if (MODE == MODE_HIDDEN) begin : g_hid
        assign d = (!x1[WD-1] && (x1 <= ONE)) ? x2 : '0;
    end else begin : g_out
        assign d = x1 - x2;
    end

    assign s   = d_q >>> shift;
    assign hi  = s > HI;
    assign lo  = s < LO;
    assign sat = hi || lo;

    always_comb begin
        qn = s[WV-1:0];
        if (hi) begin
            qn = HI[WV-1:0];
        end else if (lo) begin
            qn = LO[WV-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
            q   <= '0;
        end else begin
            if (take) begin
                d_q <= d;
            end
            if (load) begin
                q <= qn;
            end
        end
    end

endmodule

// File: rtl/delta_stage.sv
// Two-stage backprop delta generator with joined inputs and NB-way broadcast.
// Build option: DELTA_SATCNT_EN enables oSatCount; otherwise it is tied to 0.
module delta_stage
    import delta_pkg::*;
#(
    parameter string HIDDEN = "yes",
    parameter int    NP     = 5,
    parameter int    NC     = 6,
    parameter int    NN     = 7,
    parameter int    WV     = 4,
    parameter int    NB     = 2,
    parameter string BURST  = "yes",
    localparam int   MODE   = (HIDDEN == "yes") ? MODE_HIDDEN : MODE_OUTPUT,
    localparam int   WA1    = f_wa1(NP, WV),
    localparam int   WA     = f_wa(MODE, NP, NN, WV),
    localparam int   WD     = f_wd(MODE, NP, NN, WV),
    localparam int   WSH    = f_wsh(WV)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iValid_AS_Accum1,
    output logic                 oReady_AS_Accum1,
    input  logic [NC*WA1-1:0]    iData_AS_Accum1,
    input  logic                 iValid_AS_Accum2,
    output logic                 oReady_AS_Accum2,
    input  logic [NC*WA-1:0]     iData_AS_Accum2,
    input  logic [WSH-1:0]       iShift,
    output logic [NB-1:0]        oValid_BM_Delta,
    input  logic [NB-1:0]        iReady_BM_Delta,
    output logic [NB*NC*WV-1:0]  oData_BM_Delta,
    input  logic                 iClrSat,
    output logic [15:0]          oSatCount
);

    localparam bit BRST = (BURST == "yes");

    logic            v1;
    logic [NB-1:0]   pend;
    logic [WSH-1:0]  sh_q;
    logic            full2;
    logic            retire;
    logic            load2;
    logic            load1;
    logic            take;
    logic [NC-1:0]   sat;
    logic [NC*WV-1:0] q_all;

    // retire: every consumer still pending accepts in this cycle
    assign full2  = |pend;
    assign retire = full2 && ((pend & ~iReady_BM_Delta) == '0);
    assign load2  = v1 && (!full2 || (BRST && retire));
    assign load1  = !v1 || load2;
    assign take   = iValid_AS_Accum1 && iValid_AS_Accum2 && load1;

    assign oReady_AS_Accum1 = iValid_AS_Accum2 && load1;
    assign oReady_AS_Accum2 = iValid_AS_Accum1 && load1;
    assign oValid_BM_Delta  = pend;
    assign oData_BM_Delta   = {NB{q_all}};

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            v1   <= 1'b0;
            pend <= '0;
            sh_q <= '0;
        end else begin
            if (take) begin
                v1 <= 1'b1;
            end else if (load2) begin
                v1 <= 1'b0;
            end
            if (load2) begin
                pend <= '1;
            end else begin
                pend <= pend & ~iReady_BM_Delta;
            end
            if (take) begin
                sh_q <= iShift;
            end
        end
    end

    for (genvar gi = 0; gi < NC; gi++) begin : g_lane
        delta_lane #(
            .MODE (MODE),
            .WA1  (WA1),
            .WA   (WA),
            .WD   (WD),
            .WV   (WV),
            .WSH  (WSH)
        ) u_lane (
            .clk   (iCLK),
            .rst   (iRST),
            .take  (take),
            .load  (load2),
            .a1    (iData_AS_Accum1[gi*WA1+:WA1]),
            .a2    (iData_AS_Accum2[gi*WA+:WA]),
            .shift (sh_q),
            .q     (q_all[gi*WV+:WV]),
            .sat   (sat[gi])
        );
    end

`ifdef DELTA_SATCNT_EN
    localparam int WN = $clog2(NC + 1);

    logic [WN-1:0] nsat;
    logic [16:0]   sum;
    logic [15:0]   cnt;

    always_comb begin
        nsat = '0;
        for (int i = 0; i < NC; i++) begin
            nsat = nsat + WN'(sat[i]);
        end
    end

    assign sum = {1'b0, cnt} + 17'(nsat);

    // clear beats a same-cycle saturation event; count sticks at all ones
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt <= '0;
        end else if (iClrSat) begin
            cnt <= '0;
        end else if (load2) begin
            cnt <= sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    assign oSatCount = cnt;
`else
    logic unused_sat;
    assign unused_sat = iClrSat ^ (^sat);
    assign oSatCount  = '0;
`endif

endmodule

// File: tb/tb_delta_stage.sv
// Scoreboard bench for delta_stage: hidden/burst and output/non-burst builds.
module tb_delta_stage;

    localparam int NC    = 6;
    localparam int NOEXP = 999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic        rst;
    logic        h_v1, h_v2, h_r1, h_r2, h_clr;
    logic [47:0] h_d1;
    logic [41:0] h_d2;
    logic [1:0]  h_sh, h_vld, h_rdy;
    logic [47:0] h_dat;
    logic [15:0] h_sat;
    logic        o_v1, o_v2, o_r1, o_r2, o_clr;
    logic [47:0] o_d1;
    logic [47:0] o_d2;
    logic [1:0]  o_sh, o_vld, o_rdy;
    logic [47:0] o_dat;
    logic [15:0] o_sat;

    delta_stage u_hid (
        .iCLK             (clk),
        .iRST             (rst),
        .iValid_AS_Accum1 (h_v1),
        .oReady_AS_Accum1 (h_r1),
        .iData_AS_Accum1  (h_d1),
        .iValid_AS_Accum2 (h_v2),
        .oReady_AS_Accum2 (h_r2),
        .iData_AS_Accum2  (h_d2),
        .iShift           (h_sh),
        .oValid_BM_Delta  (h_vld),
        .iReady_BM_Delta  (h_rdy),
        .oData_BM_Delta   (h_dat),
        .iClrSat          (h_clr),
        .oSatCount        (h_sat)
    );

    delta_stage #(.HIDDEN("no"), .BURST("no")) u_out (
        .iCLK             (clk),
        .iRST             (rst),
        .iValid_AS_Accum1 (o_v1),
        .oReady_AS_Accum1 (o_r1),
        .iData_AS_Accum1  (o_d1),
        .iValid_AS_Accum2 (o_v2),
        .oReady_AS_Accum2 (o_r2),
        .iData_AS_Accum2  (o_d2),
        .iShift           (o_sh),
        .oValid_BM_Delta  (o_vld),
        .iReady_BM_Delta  (o_rdy),
        .oData_BM_Delta   (o_dat),
        .iClrSat          (o_clr),
        .oSatCount        (o_sat)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [23:0] hq0[$], hq1[$], oq0[$], oq1[$];
    int hcyc[$], ocyc[$];
    int exp_sat_h = 0;
    int exp_sat_o = 0;
    int last_join = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input bit hid, input int a1[NC],
                                          input int a2[NC], input int sh,
                                          output int ns);
        logic [23:0] r;
        int d;
        int s;
        r  = '0;
        ns = 0;
        for (int c = 0; c < NC; c++) begin
            if (hid) d = (a1[c] >= 0 && a1[c] <= 7) ? a2[c] : 0;
            else     d = a1[c] - a2[c];
            s = d >>> sh;
            if (s > 7) begin
                s = 7;
                ns++;
            end else if (s < -8) begin
                s = -8;
                ns++;
            end
            r[c*4+:4] = s[3:0];
        end
        return r;
    endfunction

    // channel 0 carries the directed pair, the others random values
    task automatic send(input bit hid, input int a10, input int a20,
                        input int sh, input int exp0);
        int a1[NC];
        int a2[NC];
        logic [23:0] e;
        int ns;
        bit ok;
        a1[0] = a10;
        a2[0] = a20;
        for (int c = 1; c < NC; c++) begin
            if (hid) a1[c] = int'($urandom_range(0, 14)) - 3;
            else     a1[c] = int'($urandom_range(0, 40)) - 20;
            a2[c] = int'($urandom_range(0, 40)) - 20;
        end
        for (int c = 0; c < NC; c++) begin
            if (hid) begin
                h_d1[c*8+:8] = a1[c][7:0];
                h_d2[c*7+:7] = a2[c][6:0];
            end else begin
                o_d1[c*8+:8] = a1[c][7:0];
                o_d2[c*8+:8] = a2[c][7:0];
            end
        end
        if (hid) begin
            h_sh = sh[1:0];
            h_v1 = 1'b1;
            h_v2 = 1'b1;
        end else begin
            o_sh = sh[1:0];
            o_v1 = 1'b1;
            o_v2 = 1'b1;
        end
        e = model(hid, a1, a2, sh, ns);
        if (exp0 != NOEXP) e[3:0] = exp0[3:0];
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (hid ? h_r1 : o_r1) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            check("join_timeout", 0, 1);
        end else begin
            last_join = cyc;
            if (hid) begin
                hq0.push_back(e);
                hq1.push_back(e);
                exp_sat_h += ns;
            end else begin
                oq0.push_back(e);
                oq1.push_back(e);
                exp_sat_o += ns;
            end
            @(posedge clk);
            #1;
        end
        if (hid) begin
            h_v1 = 1'b0;
            h_v2 = 1'b0;
        end else begin
            o_v1 = 1'b0;
            o_v2 = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((hq0.size() + hq1.size() + oq0.size() + oq1.size()) != 0
               && n < 60) begin
            @(posedge clk);
            n++;
        end
        check(tag, hq0.size() + hq1.size() + oq0.size() + oq1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic sat_check(input string tag, input logic [15:0] got,
                             input int exp);
`ifdef DELTA_SATCNT_EN
        check(tag, got, exp[15:0]);
`else
        check(tag, got, 16'd0);
`endif
    endtask

    always @(negedge clk) begin : mon
        logic [23:0] e;
        if (rst) begin
            hq0.delete();
            hq1.delete();
            oq0.delete();
            oq1.delete();
            exp_sat_h = 0;
            exp_sat_o = 0;
        end else begin
            if (h_vld[0] && h_rdy[0]) begin
                hcyc.push_back(cyc);
                if (hq0.size() == 0) check("h0_unexpected", 1, 0);
                else begin
                    e = hq0.pop_front();
                    check("h0_data", h_dat[23:0], e);
                end
            end
            if (h_vld[1] && h_rdy[1]) begin
                if (hq1.size() == 0) check("h1_unexpected", 1, 0);
                else begin
                    e = hq1.pop_front();
                    check("h1_data", h_dat[47:24], e);
                end
            end
            if (o_vld[0] && o_rdy[0]) begin
                ocyc.push_back(cyc);
                if (oq0.size() == 0) check("o0_unexpected", 1, 0);
                else begin
                    e = oq0.pop_front();
                    check("o0_data", o_dat[23:0], e);
                end
            end
            if (o_vld[1] && o_rdy[1]) begin
                if (oq1.size() == 0) check("o1_unexpected", 1, 0);
                else begin
                    e = oq1.pop_front();
                    check("o1_data", o_dat[47:24], e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int j0;
        logic [47:0] d0;
        rst = 1'b1;
        {h_v1, h_v2, h_clr, h_d1, h_d2, h_sh} = '0;
        {o_v1, o_v2, o_clr, o_d1, o_d2, o_sh} = '0;
        h_rdy = 2'b11;
        o_rdy = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_h_vld", h_vld, 2'b00);
        check("rst_o_vld", o_vld, 2'b00);
        check("rst_h_dat", h_dat, 48'd0);
        check("rst_h_sat", h_sat, 16'd0);
        check("rst_o_sat", o_sat, 16'd0);
        @(posedge clk);
        #1;

        send(1, 5, 3, 0, 3);
        send(1, 8, 3, 0, 0);
        send(1, -1, 3, 0, 0);
        send(1, 7, -6, 0, -6);
        drain("hid_dir");
        sat_check("hid_sat", h_sat, exp_sat_h);

        send(0, 6, -7, 0, 7);
        send(0, -8, 7, 0, -8);
        send(0, 0, 5, 1, -3);
        send(0, 5, 0, 1, 2);
        drain("out_dir");
        sat_check("out_sat", o_sat, exp_sat_o);
        o_clr = 1'b1;
        @(posedge clk);
        #1 o_clr = 1'b0;
        exp_sat_o = 0;
        check("out_sat_clr", o_sat, 16'd0);

        hcyc.delete();
        j0 = 0;
        for (int i = 0; i < 8; i++) begin
            send(1, i - 2, 3 - i, i % 4, NOEXP);
            if (i == 0) j0 = last_join;
        end
        drain("hid_burst");
        check("hb_count", hcyc.size(), 8);
        if (hcyc.size() == 8) begin
            check("hb_latency", hcyc[0], j0 + 2);
            check("hb_span", hcyc[7] - hcyc[0], 7);
        end

        ocyc.delete();
        for (int i = 0; i < 8; i++) begin
            send(0, 2 * i - 7, i - 3, i % 4, NOEXP);
            if (i == 0) j0 = last_join;
        end
        drain("out_burst");
        check("ob_count", ocyc.size(), 8);
        if (ocyc.size() == 8) begin
            check("ob_latency", ocyc[0], j0 + 2);
            check("ob_span", ocyc[7] - ocyc[0], 14);
        end
        sat_check("out_sat2", o_sat, exp_sat_o);

        h_rdy = 2'b01;
        send(1, 1, 2, 0, 2);
        send(1, 2, 5, 0, 5);
        fork
            send(1, 3, -4, 0, -4);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_upstream_rdy", h_r1, 1'b0);
                    if (i == 0) begin
                        d0 = h_dat;
                        check("bp_vld_first", h_vld, 2'b11);
                    end else begin
                        check("bp_vld_stall", h_vld, 2'b10);
                        check("bp_hold", h_dat, d0);
                    end
                end
                @(posedge clk);
                #1 h_rdy = 2'b11;
                @(negedge clk);
                check("bp_c1_take", h_vld, 2'b10);
            end
        join
        drain("bp");
        sat_check("hid_sat2", h_sat, exp_sat_h);

        h_rdy = 2'b00;
        send(1, 4, 6, 0, 6);
        send(1, 6, -2, 0, -2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst2_h_vld", h_vld, 2'b00);
        check("rst2_o_vld", o_vld, 2'b00);
        check("rst2_h_sat", h_sat, 16'd0);
        check("rst2_o_sat", o_sat, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        h_rdy = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst2_stale", h_vld, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
